// File: rtl/spi_master_16bit.sv
// SPI mode-0 master for 16-bit MSB-first frames; SCLK is derived from clk_in by a
// half-period counter, so the whole block lives in one clock domain.
module spi_master_16bit #(
    parameter int CLK_DIV = 6
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] tx_data,
    input  logic        SPI_MISO,
    output logic        SPI_CS,
    output logic        SPI_SCLK,
    output logic        SPI_MOSI,
    output logic [15:0] rx_data,
    output logic        busy,
    output logic        done
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    // Falling edge 15 is the 31st SCLK toggle after rising edge 0.
    localparam logic [4:0] LAST_TOGGLE = 5'd30;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   div_q;
    logic [4:0]      edge_q;
    logic [14:0]     tx_sr_q;
    logic [15:0]     rx_sr_q;
    logic [15:0]     rx_data_q;
    logic            cs_q;
    logic            sclk_q;
    logic            mosi_q;
    logic            busy_q;
    logic            done_q;
    logic            half_done;

    assign half_done = (div_q == DIV_LAST);

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            edge_q    <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    div_q <= '0;
                    if (start) begin
                        tx_sr_q <= tx_data[14:0];
                        mosi_q  <= tx_data[15];
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        edge_q  <= '0;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (half_done) begin
                        div_q   <= '0;
                        sclk_q  <= 1'b1;
                        rx_sr_q <= {rx_sr_q[14:0], SPI_MISO};
                        state_q <= S_SHIFT;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (half_done) begin
                        div_q  <= '0;
                        edge_q <= edge_q + 1'b1;
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                            if (edge_q == LAST_TOGGLE) begin
                                state_q <= S_HOLD;
                            end else begin
                                mosi_q  <= tx_sr_q[14];
                                tx_sr_q <= {tx_sr_q[13:0], 1'b0};
                            end
                        end else begin
                            sclk_q  <= 1'b1;
                            rx_sr_q <= {rx_sr_q[14:0], SPI_MISO};
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (half_done) begin
                        div_q     <= '0;
                        cs_q      <= 1'b1;
                        mosi_q    <= 1'b0;
                        rx_data_q <= rx_sr_q;
                        done_q    <= 1'b1;
                        state_q   <= S_GAP;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (half_done) begin
                        div_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign SPI_CS   = cs_q;
    assign SPI_SCLK = sclk_q;
    assign SPI_MOSI = mosi_q;
    assign rx_data  = rx_data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
